// File: rtl/vend_pkg.sv
// vend_pkg: shared codes, state encodings and widths for the vending datapath.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package vend_pkg;

  // Width of the change-owed field carried with done.
  localparam int CHANGE_W = 3;

  // Largest change the dispenser will pay; larger requests are clipped to this.
  localparam logic [CHANGE_W-1:0] CHANGE_MAX = 3'd4;

  // Coin tube level counters (only meaningful with COIN_INVENTORY_EN).
  localparam int TUBE_W = 8;

  // Product codes, shared with the upstream vending FSM and the motor drive.
  localparam logic [1:0] PROD_NONE  = 2'b00;
  localparam logic [1:0] PROD_CHOC  = 2'b01;
  localparam logic [1:0] PROD_DRINK = 2'b10;

  // Coin input codes used by the upstream vending FSM.
  localparam logic [1:0] COIN_ONE  = 2'b00;
  localparam logic [1:0] COIN_TWO  = 2'b01;
  localparam logic [1:0] COIN_FIVE = 2'b10;
  localparam logic [1:0] COIN_IDLE = 2'b11;

  // Dispenser FSM encoding, kept as plain constants for legacy tools.
  typedef logic [1:0] disp_state_t;
  localparam disp_state_t ST_IDLE = 2'd0;
  localparam disp_state_t ST_VEND = 2'd1;
  localparam disp_state_t ST_PAY  = 2'd2;
  localparam disp_state_t ST_FIN  = 2'd3;

  // Clip an out-of-range change request to the largest payable amount.
  function automatic logic [CHANGE_W-1:0] sat_change(input logic [CHANGE_W-1:0] c);
    return (c > CHANGE_MAX) ? CHANGE_MAX : c;
  endfunction

endpackage

// File: rtl/vend_ack_timer.sv
// vend_ack_timer: counts cycles spent waiting for an ack; expired once TIMEOUT_CYCLES waits have elapsed.
// Latency: load makes the next cycle wait number 1; expired is a combinational decode of the count.
// Backpressure: none; the count saturates at the limit until the next load.
module vend_ack_timer #(
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic tick,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] FIRST = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: restart on load, otherwise advance one per waiting cycle up to the limit.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = FIRST;
    end else if (tick && (cnt_q < LIMIT)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q >= LIMIT);

endmodule

// File: rtl/vend_dispenser.sv
// vend_dispenser: latches a vend result, runs the product motor, then pays change as 2-unit then 1-unit coins.
// Latency: done at T -> vend_motor (or dispensed for an empty vend) at T+1; one idle gap cycle between coins.
// Backpressure: waits on vend_ack/coin_ack handshakes; no ack within TIMEOUT_CYCLES -> sticky fault.
// Build option COIN_INVENTORY_EN: tracks tube levels, substitutes 1-unit coins, faults on shortfall.
module vend_dispenser
  import vend_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int TUBE1_INIT     = 8,
  parameter int TUBE2_INIT     = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       done,
  input  logic [1:0] product,
  input  logic [2:0] change,
  output logic [1:0] vend_motor,
  input  logic       vend_ack,
  output logic       coin_eject,
  output logic       coin_sel,
  input  logic       coin_ack,
  output logic       busy,
  output logic       dispensed,
  output logic       fault
);

  if (TIMEOUT_CYCLES < 2 || TUBE1_INIT < 0 || TUBE2_INIT < 0 ||
      TUBE1_INIT >= (1 << TUBE_W) || TUBE2_INIT >= (1 << TUBE_W)) begin : g_bad_param
    $error("vend_dispenser: parameter out of range");
  end

  disp_state_t state_q, state_d;
  logic [1:0]  prod_q, prod_d;
  logic [1:0]  n2_q, n2_d;        // 2-unit coins still owed (0..2)
  logic [2:0]  n1_q, n1_d;        // 1-unit coins still owed (0..5 after substitution)
  logic        gap_q, gap_d;      // forced idle cycle between two coin requests
  logic        fault_q, fault_d;

  logic [CHANGE_W-1:0] chg_sat;
  logic [1:0]  cap_n2;
  logic [2:0]  cap_n1;
  logic        is_prod;
  logic        enter_pay;
  logic [1:0]  ent_n2;
  logic [2:0]  ent_n1;
  logic [1:0]  pe_n2;
  logic [2:0]  pe_n1;
  logic        pe_short;
  logic        last_coin;

  logic        tmr_load;
  logic        tmr_tick;
  logic        tmr_expired;

`ifdef COIN_INVENTORY_EN
  logic [TUBE_W-1:0] tube1_q, tube1_d;
  logic [TUBE_W-1:0] tube2_q, tube2_d;
  logic [1:0]        take2;
  logic [1:0]        short2;
`endif

  vend_ack_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .load   (tmr_load),
    .tick   (tmr_tick),
    .expired(tmr_expired)
  );

  // Decode the incoming request and work out the coin plan used on entry to PAY.
  always_comb begin
    chg_sat = sat_change(change);
    cap_n2  = chg_sat[2:1];
    cap_n1  = {2'b00, chg_sat[0]};
    is_prod = (product == PROD_CHOC) || (product == PROD_DRINK);
    // PAY is entered either straight from IDLE (fresh capture) or after the motor run.
    ent_n2  = (state_q == ST_IDLE) ? cap_n2 : n2_q;
    ent_n1  = (state_q == ST_IDLE) ? cap_n1 : n1_q;
    last_coin = ((n2_q == 2'd1) && (n1_q == 3'd0)) || ((n2_q == 2'd0) && (n1_q == 3'd1));
`ifdef COIN_INVENTORY_EN
    // Pay as many 2-unit coins as the tube holds; each missing one becomes two 1-unit coins.
    take2    = (TUBE_W'(ent_n2) <= tube2_q) ? ent_n2 : tube2_q[1:0];
    short2   = ent_n2 - take2;
    pe_n2    = take2;
    pe_n1    = ent_n1 + {short2, 1'b0};
    pe_short = (TUBE_W'(pe_n1) > tube1_q);
`else
    pe_n2    = ent_n2;
    pe_n1    = ent_n1;
    pe_short = 1'b0;
`endif
  end

  // Transaction FSM: capture, motor run, coin payout, completion, plus timeout/overrun supervision.
  always_comb begin
    state_d   = state_q;
    prod_d    = prod_q;
    n2_d      = n2_q;
    n1_d      = n1_q;
    gap_d     = 1'b0;
    fault_d   = fault_q;
    enter_pay = 1'b0;
    tmr_load  = 1'b0;
    tmr_tick  = 1'b0;
`ifdef COIN_INVENTORY_EN
    tube1_d   = tube1_q;
    tube2_d   = tube2_q;
`endif

    // A new result while still busy cannot be queued; flag it and finish the current one.
    if (done && (state_q != ST_IDLE)) begin
      fault_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (done && !fault_q) begin
          prod_d = is_prod ? product : PROD_NONE;
          n2_d   = cap_n2;
          n1_d   = cap_n1;
          if (is_prod) begin
            state_d  = ST_VEND;
            tmr_load = 1'b1;
          end else if (chg_sat != '0) begin
            enter_pay = 1'b1;
          end else begin
            state_d = ST_FIN;
          end
        end
      end

      ST_VEND: begin
        if (vend_ack) begin
          if ((n2_q != 2'd0) || (n1_q != 3'd0)) begin
            enter_pay = 1'b1;
          end else begin
            state_d = ST_FIN;
          end
        end else if (tmr_expired) begin
          fault_d = 1'b1;
          state_d = ST_IDLE;
        end else begin
          tmr_tick = 1'b1;
        end
      end

      ST_PAY: begin
        if (gap_q) begin
          // Gap cycle: the next request starts a fresh wait.
          tmr_load = 1'b1;
        end else if (coin_ack) begin
          if (n2_q != 2'd0) begin
            n2_d = n2_q - 1'b1;
`ifdef COIN_INVENTORY_EN
            tube2_d = tube2_q - 1'b1;
`endif
          end else begin
            n1_d = n1_q - 1'b1;
`ifdef COIN_INVENTORY_EN
            tube1_d = tube1_q - 1'b1;
`endif
          end
          if (last_coin) begin
            state_d = ST_FIN;
          end else begin
            gap_d = 1'b1;
          end
        end else if (tmr_expired) begin
          fault_d = 1'b1;
          state_d = ST_IDLE;
        end else begin
          tmr_tick = 1'b1;
        end
      end

      ST_FIN: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Entering PAY: commit the coin plan, or refuse the whole payout if the tubes cannot cover it.
    // A refused payout returns straight to IDLE, so a change-only request never shows busy.
    if (enter_pay) begin
      if (pe_short) begin
        fault_d = 1'b1;
        state_d = ST_IDLE;
      end else begin
        state_d  = ST_PAY;
        n2_d     = pe_n2;
        n1_d     = pe_n1;
        tmr_load = 1'b1;
      end
    end
  end

  // State and datapath registers; reset abandons any transaction in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      prod_q  <= PROD_NONE;
      n2_q    <= '0;
      n1_q    <= '0;
      gap_q   <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      prod_q  <= prod_d;
      n2_q    <= n2_d;
      n1_q    <= n1_d;
      gap_q   <= gap_d;
      fault_q <= fault_d;
    end
  end

`ifdef COIN_INVENTORY_EN
  // Coin tube levels, reloaded to their fill values on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      tube1_q <= TUBE_W'(TUBE1_INIT);
      tube2_q <= TUBE_W'(TUBE2_INIT);
    end else begin
      tube1_q <= tube1_d;
      tube2_q <= tube2_d;
    end
  end
`endif

  // Outputs decode registered state only, so they never follow inputs combinationally.
  always_comb begin
    vend_motor = (state_q == ST_VEND) ? prod_q : PROD_NONE;
    coin_eject = (state_q == ST_PAY) && !gap_q;
    coin_sel   = (state_q == ST_PAY) && (n2_q != 2'd0);
    busy       = (state_q != ST_IDLE);
    dispensed  = (state_q == ST_FIN);
    fault      = fault_q;
  end

endmodule

// File: doc/vend_dispenser.md
Name: vend_dispenser

Overview:
- Downstream stage of the vending FSM.
- Latches the one-cycle `done`/`product`/`change` result and drives the product motor.
- Then pays out change as 2-unit and 1-unit coins through the coin ejector, with ack handshakes and timeout supervision.
- Reports busy, completion and fault status to the front panel.

Parameters:
- TIMEOUT_CYCLES, 1000, max cycles to wait for any ack before declaring fault (>=2)
- TUBE1_INIT, 8, initial 1-unit coin count (used only with COIN_INVENTORY_EN)
- TUBE2_INIT, 8, initial 2-unit coin count (used only with COIN_INVENTORY_EN)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- done  in  1  one-cycle vend-complete strobe from vending FSM
- product  in  2  01=chocolate, 10=drink, 00/11=none; valid with done
- change  in  3  change owed in 1-unit coins (0..4); valid with done
- vend_motor  out  2  one-hot motor drive, same encoding as product
- vend_ack  in  1  product-dropped sensor, level
- coin_eject  out  1  eject request, held until coin_ack
- coin_sel  out  1  0=1-unit tube, 1=2-unit tube; stable while coin_eject=1
- coin_ack  in  1  coin-passed sensor
- busy  out  1  transaction in progress
- dispensed  out  1  one-cycle pulse at successful completion
- fault  out  1  sticky: timeout, overrun or inventory shortfall

Behaviour:
- Reset: all outputs 0, state IDLE, counters cleared, fault cleared; tubes reload to INIT values when COIN_INVENTORY_EN is defined.
- Reset mid-transaction aborts it immediately; no outputs persist.
- States: IDLE, VEND, PAY, FIN.
- IDLE:
  - Takes a transaction when done=1 and fault=0.
  - Captures n2=change>>1 and n1=change[0].
  - Goes to VEND if product is 01 or 10, otherwise to PAY if change!=0, otherwise to FIN.
  - done while fault=1 is ignored.
- VEND:
  - vend_motor=captured product.
  - When vend_ack=1 is sampled: motor off next cycle, go to PAY if n2+n1>0, else FIN.
- PAY:
  - 2-unit coins are paid first.
  - coin_sel=1 while n2>0, else 0.
  - coin_eject=1 until coin_ack=1 is sampled; that ack decrements the selected count and drops coin_eject for exactly one cycle (gap) before the next request.
  - When both counts reach 0, go to FIN.
- FIN: dispensed=1 for one cycle, then IDLE.
- busy=1 from the cycle after accepted done through the FIN cycle inclusive.
- Latency: done at cycle T gives vend_motor at T+1; a zero-change, no-product done gives dispensed at T+1.
- Timeout:
  - Wait counter resets on entry to VEND and on every new coin_eject request.
  - Reaching TIMEOUT_CYCLES without ack sets fault, drops all drives, and returns to IDLE; no dispensed pulse.
- Overrun: done=1 while busy=1 sets fault; the current transaction completes normally.
- change values 5..7 are treated as 4.
- Acks seen outside their wait state are ignored.

Optional Feature:
- Macro: COIN_INVENTORY_EN.
- Defined:
  - Tube counters, decremented on each acked coin.
  - If the 2-unit tube is empty while n2>0, each pending 2-unit coin is converted to two 1-unit coins.
  - If the remaining 1-unit need exceeds the 1-unit tube at PAY entry, set fault and pay nothing.
- Not defined: no counters; tubes are treated as infinite; TUBE*_INIT are unused.

Decomposition:
- Shared package (vend_pkg):
  - product codes (NONE/CHOC/DRINK)
  - coin input codes (ONE=00, TWO=01, FIVE=10, IDLE=11)
  - dispenser state enum
  - change width constant (3)
- One sub-module, vend_ack_timer: loadable wait counter with load, tick and expired signals.

Test Plan:
- done, product=01, change=0; vend_ack 3 cycles later -> vend_motor=01 from T+1, dispensed one cycle after ack-driven FIN, no coin_eject.
- done, product=10, change=3; immediate acks -> one coin_sel=1 eject then one coin_sel=0 eject, 1-cycle gap between, then dispensed.
- change=4, product=00 -> two 2-unit ejects, vend_motor never asserted.
- TIMEOUT_CYCLES=16, vend_ack withheld -> fault=1 at cycle 16 of VEND, motor off, busy=0, no dispensed; later done ignored.
- done pulsed again during PAY -> fault=1, current transaction still completes.
- COIN_INVENTORY_EN, TUBE2_INIT=0, change=2 -> two 1-unit ejects; with TUBE1_INIT=1 as well -> fault, no ejects.
